// File: rtl/flit_packetizer_if.sv
// Message-in / flit-out bundle for the flit packetizer.
// master = packetizer side, slave = device/network side.
interface flit_packetizer_if #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 2,
  parameter int VC_BITS         = 1,
  parameter int MAX_FLITS       = 4
);
  localparam int LEN_BITS   = $clog2(MAX_FLITS);
  localparam int MSG_WIDTH  = MAX_FLITS * FLIT_DATA_WIDTH;
  localparam int FLIT_WIDTH = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;

  logic [MSG_WIDTH-1:0]  msg_data;
  logic [DEST_BITS-1:0]  msg_dest;
  logic [LEN_BITS-1:0]   msg_len;
  logic                  msg_valid;
  logic                  msg_ready;
  logic [FLIT_WIDTH-1:0] put_flit;
  logic                  put_flit_valid;
  logic                  put_flit_ready;
  logic                  busy;
  logic [15:0]           pkts_sent;

  modport master (
    input  msg_data, msg_dest, msg_len, msg_valid,
    input  put_flit_ready,
    output msg_ready, put_flit, put_flit_valid,
    output busy, pkts_sent
  );

  modport slave (
    output msg_data, msg_dest, msg_len, msg_valid,
    output put_flit_ready,
    input  msg_ready, put_flit, put_flit_valid,
    input  busy, pkts_sent
  );
endinterface

// File: rtl/flit_packetizer.sv
// Splits one wide device message into 1..MAX_FLITS flits
// with valid/tail/dest/vc stamped on each, all outputs registered.
module flit_packetizer #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 2,
  parameter int VC_BITS         = 1,
  parameter int MAX_FLITS       = 4,
  parameter     DEVICE_TYPE     = "MASTER"
) (
  input logic               CLK,
  input logic               RST,
  flit_packetizer_if.master bus
);
  localparam int LEN_BITS   = $clog2(MAX_FLITS);
  localparam int FLIT_WIDTH = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;
  localparam logic [VC_BITS-1:0] VC =
    (DEVICE_TYPE == "MASTER") ? VC_BITS'(1) : '0;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state;
  logic [LEN_BITS-1:0]        beat;
  logic [LEN_BITS-1:0]        len_q;
  logic [DEST_BITS-1:0]       dest_q;
  logic [FLIT_DATA_WIDTH-1:0] words [MAX_FLITS];
  logic [15:0]                pkts_q;
  logic                       valid_q;
  logic                       ready_q;
  logic                       busy_q;
  logic [FLIT_WIDTH-1:0]      flit_q;
  logic [LEN_BITS-1:0]        nxt;
  logic                       tail;

  assign nxt  = beat + LEN_BITS'(1);
  assign tail = (beat == len_q);

  function automatic logic [FLIT_WIDTH-1:0] mk_flit(
    input logic                       t,
    input logic [DEST_BITS-1:0]       d,
    input logic [FLIT_DATA_WIDTH-1:0] p
  );
    return {1'b1, t, d, VC, p};
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      beat    <= '0;
      len_q   <= '0;
      dest_q  <= '0;
      pkts_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      flit_q  <= '0;
      for (int i = 0; i < MAX_FLITS; i++)
        words[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.msg_valid) begin
            for (int i = 0; i < MAX_FLITS; i++)
              words[i] <= bus.msg_data[i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
            len_q   <= bus.msg_len;
            dest_q  <= bus.msg_dest;
            beat    <= '0;
            state   <= SEND;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            flit_q  <= mk_flit(bus.msg_len == '0, bus.msg_dest,
                               bus.msg_data[FLIT_DATA_WIDTH-1:0]);
          end
        end
        SEND: begin
          if (bus.put_flit_ready) begin
            if (tail) begin
              pkts_q  <= pkts_q + 16'd1;
              state   <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              flit_q  <= '0;
            end else begin
              // Preload the next beat so the flit stays a plain register.
              beat   <= nxt;
              flit_q <= mk_flit(nxt == len_q, dest_q, words[nxt]);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.msg_ready      = ready_q;
  assign bus.put_flit       = flit_q;
  assign bus.put_flit_valid = valid_q;
  assign bus.busy           = busy_q;
  assign bus.pkts_sent      = pkts_q;
endmodule

// File: tb/tb_flit_packetizer.sv
// Directed bench for flit_packetizer: MASTER and SLAVE
// instances, hand-computed flits, immediate assertions.
module tb_flit_packetizer;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   compared = 0;
  int   mismatched = 0;

  always #5 CLK = ~CLK;

  flit_packetizer_if #(.FLIT_DATA_WIDTH(32), .DEST_BITS(2),
                       .VC_BITS(1), .MAX_FLITS(4)) mif ();
  flit_packetizer_if #(.FLIT_DATA_WIDTH(32), .DEST_BITS(2),
                       .VC_BITS(1), .MAX_FLITS(4)) sif ();

  flit_packetizer #(.DEVICE_TYPE("MASTER")) m_dut (
    .CLK(CLK), .RST(RST), .bus(mif.master));
  flit_packetizer #(.DEVICE_TYPE("SLAVE")) s_dut (
    .CLK(CLK), .RST(RST), .bus(sif.master));

  function automatic logic [36:0] mk(
    input logic t, input logic [1:0] d,
    input logic v, input logic [31:0] p);
    return {1'b1, t, d, v, p};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    mif.msg_data = '0; mif.msg_dest = '0; mif.msg_len = '0;
    mif.msg_valid = 1'b0; mif.put_flit_ready = 1'b1;
    sif.msg_data = '0; sif.msg_dest = '0; sif.msg_len = '0;
    sif.msg_valid = 1'b0; sif.put_flit_ready = 1'b1;

    #3;
    chk("rst_valid", 64'(mif.put_flit_valid), 64'd0);
    chk("rst_busy", 64'(mif.busy), 64'd0);
    chk("rst_flit", 64'(mif.put_flit), 64'd0);
    chk("rst_pkts", 64'(mif.pkts_sent), 64'd0);
    #4 RST = 1'b0;
    tick();
    chk("idle_ready", 64'(mif.msg_ready), 64'd1);

    // 1 + 5: four-flit MASTER message, inputs scrambled mid-packet
    mif.msg_data  = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    mif.msg_dest  = 2'd2;
    mif.msg_len   = 2'd3;
    mif.msg_valid = 1'b1;
    tick();
    mif.msg_valid = 1'b0;
    mif.msg_data  = 128'hDEAD_0000_DEAD_0000_DEAD_0000_DEAD_0000;
    mif.msg_dest  = 2'd1;
    mif.msg_len   = 2'd0;
    chk("t1_f0", 64'(mif.put_flit), 64'(mk(0, 2, 1, 32'h1111_1111)));
    chk("t1_busy", 64'(mif.busy), 64'd1);
    chk("t1_rdy0", 64'(mif.msg_ready), 64'd0);
    tick();
    chk("t1_f1", 64'(mif.put_flit), 64'(mk(0, 2, 1, 32'h2222_2222)));
    tick();
    chk("t1_f2", 64'(mif.put_flit), 64'(mk(0, 2, 1, 32'h3333_3333)));
    tick();
    chk("t1_f3", 64'(mif.put_flit), 64'(mk(1, 2, 1, 32'h4444_4444)));
    tick();
    chk("t1_end_valid", 64'(mif.put_flit_valid), 64'd0);
    chk("t1_end_ready", 64'(mif.msg_ready), 64'd1);
    chk("t1_end_busy", 64'(mif.busy), 64'd0);
    chk("t1_pkts", 64'(mif.pkts_sent), 64'd1);

    // 2: single-flit SLAVE message
    sif.msg_data  = {96'h0, 32'hDEAD_BEEF};
    sif.msg_dest  = 2'd1;
    sif.msg_len   = 2'd0;
    sif.msg_valid = 1'b1;
    tick();
    sif.msg_valid = 1'b0;
    chk("t2_flit", 64'(sif.put_flit), 64'(mk(1, 1, 0, 32'hDEAD_BEEF)));
    chk("t2_valid", 64'(sif.put_flit_valid), 64'd1);
    tick();
    chk("t2_pkts", 64'(sif.pkts_sent), 64'd1);
    chk("t2_valid_off", 64'(sif.put_flit_valid), 64'd0);

    // 3: backpressure on beat 1
    mif.msg_data  = 128'h0_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0;
    mif.msg_dest  = 2'd3;
    mif.msg_len   = 2'd2;
    mif.msg_valid = 1'b1;
    tick();
    mif.msg_valid = 1'b0;
    chk("t3_f0", 64'(mif.put_flit), 64'(mk(0, 3, 1, 32'hA0A0_A0A0)));
    tick();
    mif.put_flit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold", 64'(mif.put_flit), 64'(mk(0, 3, 1, 32'hA1A1_A1A1)));
      chk("t3_hold_v", 64'(mif.put_flit_valid), 64'd1);
      tick();
    end
    mif.put_flit_ready = 1'b1;
    chk("t3_f1", 64'(mif.put_flit), 64'(mk(0, 3, 1, 32'hA1A1_A1A1)));
    tick();
    chk("t3_f2", 64'(mif.put_flit), 64'(mk(1, 3, 1, 32'hA2A2_A2A2)));
    tick();
    chk("t3_done", 64'(mif.put_flit_valid), 64'd0);
    chk("t3_pkts", 64'(mif.pkts_sent), 64'd2);

    // 4: async reset during beat 2 of 4
    mif.msg_data  = 128'hB3B3_B3B3_B2B2_B2B2_B1B1_B1B1_B0B0_B0B0;
    mif.msg_dest  = 2'd0;
    mif.msg_len   = 2'd3;
    mif.msg_valid = 1'b1;
    tick();
    mif.msg_valid = 1'b0;
    tick();
    tick();
    chk("t4_f2", 64'(mif.put_flit), 64'(mk(0, 0, 1, 32'hB2B2_B2B2)));
    #2 RST = 1'b1;
    #1;
    chk("t4_rst_valid", 64'(mif.put_flit_valid), 64'd0);
    chk("t4_rst_busy", 64'(mif.busy), 64'd0);
    chk("t4_rst_flit", 64'(mif.put_flit), 64'd0);
    chk("t4_rst_pkts", 64'(mif.pkts_sent), 64'd0);
    #2 RST = 1'b0;
    tick();
    chk("t4_ready", 64'(mif.msg_ready), 64'd1);
    mif.msg_data  = 128'h0_C1C1_C1C1_C0C0_C0C0;
    mif.msg_dest  = 2'd1;
    mif.msg_len   = 2'd1;
    mif.msg_valid = 1'b1;
    tick();
    mif.msg_valid = 1'b0;
    chk("t4_n0", 64'(mif.put_flit), 64'(mk(0, 1, 1, 32'hC0C0_C0C0)));
    tick();
    chk("t4_n1", 64'(mif.put_flit), 64'(mk(1, 1, 1, 32'hC1C1_C1C1)));
    tick();
    chk("t4_pkts", 64'(mif.pkts_sent), 64'd1);

    // 6: counter wrap
    m_dut.pkts_q = 16'hFFFE;
    mif.msg_data  = {96'h0, 32'h0000_0001};
    mif.msg_dest  = 2'd2;
    mif.msg_len   = 2'd0;
    mif.msg_valid = 1'b1;
    tick();
    mif.msg_valid = 1'b0;
    tick();
    chk("t6_ffff", 64'(mif.pkts_sent), 64'hFFFF);
    mif.msg_valid = 1'b1;
    tick();
    mif.msg_valid = 1'b0;
    chk("t6_flit", 64'(mif.put_flit), 64'(mk(1, 2, 1, 32'h0000_0001)));
    tick();
    chk("t6_wrap", 64'(mif.pkts_sent), 64'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
